// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encodings for the UART-to-memory-bus debug bridge.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_ACK     = 8'h4B;
    localparam logic [7:0] RSP_ERR     = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    function automatic int baud_cnt_width(input int baud_div);
        return (baud_div > 1) ? $clog2(baud_div) : 1;
    endfunction

endpackage

// File: rtl/uart_serdes.sv
// 8N1 receiver and transmitter sharing one baud divisor.
// The transmitter accepts a new byte in the last stop-bit cycle so frames can run back-to-back.
module uart_serdes
    import uart_bus_master_pkg::*;
#(
    parameter int BAUD_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx
);
    localparam int            CW       = baud_cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;

    logic [9:0]    tx_sh_q, tx_sh_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          tx_active_q, tx_active_d;
    logic          tx_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_active_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_active_q <= tx_active_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_BITS;
            end
            RX_BITS: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_valid   = rx_sync_q;
                rx_ferr    = !rx_sync_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = rx_sh_q;
    assign tx_last = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CNT_LAST);
    assign tx_busy = tx_active_q && !tx_last;
    assign tx      = tx_sh_q[0];

    // Idle shifter holds all ones, so the line rests high without extra muxing.
    always_comb begin
        tx_sh_d     = tx_sh_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_active_d = tx_active_q;
        if (tx_active_q) begin
            if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_last) tx_active_d = 1'b0;
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
        end
        if (tx_start && !tx_busy) begin
            tx_sh_d     = {1'b1, tx_byte, 1'b0};
            tx_cnt_d    = '0;
            tx_bit_d    = '0;
            tx_active_d = 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Command decoder: turns 'W'/'R' serial frames into single mem_* bus transactions
// and streams the acknowledge, timeout or read data back out on tx.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int BAUD_DIV = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
    logic [2:0]    resp_len_q, resp_len_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [7:0]    rx_byte, tx_byte;
    logic          rx_valid, rx_ferr, tx_start, tx_busy;

    uart_serdes #(.BAUD_DIV(BAUD_DIV)) u_serdes (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            resp_len_q <= '0;
            wstrb_q    <= '0;
            valid_q    <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            resp_len_q <= resp_len_d;
            wstrb_q    <= wstrb_d;
            valid_q    <= valid_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_len_d = resp_len_q;
        wstrb_d    = wstrb_q;
        valid_d    = valid_q;
        timer_d    = timer_q;
        tx_start   = 1'b0;
        tx_byte    = resp_q[31:24];
        unique case (state_q)
            ST_IDLE: if (rx_valid) begin
                byte_cnt_d = '0;
                if (rx_byte == CMD_WRITE) begin
                    write_d = 1'b1;
                    state_d = ST_ADDR;
                end else if (rx_byte == CMD_READ) begin
                    write_d = 1'b0;
                    state_d = ST_ADDR;
                end else begin
                    resp_d     = {RSP_ERR, 24'h0};
                    resp_len_d = 3'd1;
                    state_d    = ST_RESP;
                end
            end
            ST_ADDR: if (rx_ferr) begin
                state_d = ST_IDLE;
            end else if (rx_valid) begin
                addr_d     = {addr_q[23:0], rx_byte};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) state_d = write_q ? ST_DATA : ST_BUS;
            end
            ST_DATA: if (rx_ferr) begin
                state_d = ST_IDLE;
            end else if (rx_valid) begin
                wdata_d    = {wdata_q[23:0], rx_byte};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) state_d = ST_BUS;
            end
            ST_BUS: begin
                timer_d = timer_q + TW'(1);
                // Ready on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    valid_d    = 1'b0;
                    state_d    = ST_RESP;
                    resp_d     = write_q ? {RSP_ACK, 24'h0} : mem_rdata;
                    resp_len_d = write_q ? 3'd1 : 3'd4;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    valid_d    = 1'b0;
                    state_d    = ST_RESP;
                    resp_d     = {RSP_TIMEOUT, 24'h0};
                    resp_len_d = 3'd1;
                end
            end
            ST_RESP: if (!tx_busy) begin
                tx_start   = 1'b1;
                resp_d     = {resp_q[23:0], 8'h00};
                resp_len_d = resp_len_q - 3'd1;
                if (resp_len_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_BUS && state_q != ST_BUS) begin
            valid_d = 1'b1;
            wstrb_d = write_q ? 4'hF : 4'h0;
            timer_d = '0;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign frame_err = rx_ferr;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench: stimulus pushes expected bus cycles and tx bytes, independent
// monitors decode the bus and the tx line and pop/compare.
`timescale 1ns/1ps
module tb_uart_bus_master;
    localparam int BAUD_DIV = 10;
    localparam int TIMEOUT  = 64;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        tx, mem_valid, frame_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    uart_bus_master #(.BAUD_DIV(BAUD_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dur;
    } bus_exp_t;

    typedef struct {
        logic [7:0] b;
        bit         b2b;
    } tx_exp_t;

    bus_exp_t    bus_q[$];
    tx_exp_t     tx_q[$];
    logic [31:0] model_mem [8];
    logic [31:0] rsp_mem [8];
    int          rsp_delay = 0;
    int          ferr_count = 0;
    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= 32'h8000_0200) && (a <= 32'h8000_021F);
    endfunction

    task automatic push_tx(input logic [7:0] b, input bit b2b);
        tx_exp_t t;
        t.b = b;
        t.b2b = b2b;
        tx_q.push_back(t);
    endtask

    // Reference: in-range accesses hit a word memory, anything else times out.
    task automatic model_cmd(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        bus_exp_t    e;
        logic [31:0] w;
        e.addr  = a;
        e.wdata = d;
        e.wstrb = is_wr ? 4'hF : 4'h0;
        if (in_range(a)) begin
            e.dur = rsp_delay + 1;
            if (is_wr) begin
                model_mem[a[4:2]] = d;
                push_tx(8'h4B, 1'b0);
            end else begin
                w = model_mem[a[4:2]];
                for (int i = 3; i >= 0; i--) push_tx(w[8*i +: 8], i != 3);
            end
        end else begin
            e.dur = TIMEOUT;
            push_tx(8'h54, 1'b0);
        end
        bus_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus_q.size() != 0 || tx_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(bus_q.size() + tx_q.size()), 32'd0);
        bus_q.delete();
        tx_q.delete();
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic send_cmd(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        model_cmd(is_wr, a, d);
        send_byte(is_wr ? 8'h57 : 8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        if (is_wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
        wait_idle();
    endtask

    // Responder: ready after rsp_delay cycles for the decoded window, never otherwise.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && !reset) begin
                if (in_range(mem_addr) && k == rsp_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = rsp_mem[mem_addr[4:2]];
                    if (mem_wstrb == 4'hF) rsp_mem[mem_addr[4:2]] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom();
                end
                k++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom();
                k = 0;
            end
        end
    end

    // Bus monitor
    initial begin
        bus_exp_t    e;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          dur;
        bit          stable;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                a = mem_addr;
                d = mem_wdata;
                s = mem_wstrb;
                dur = 0;
                stable = 1'b1;
                while (mem_valid === 1'b1) begin
                    dur++;
                    if (mem_addr !== a || mem_wdata !== d || mem_wstrb !== s) stable = 1'b0;
                    @(negedge clk);
                end
                check("bus_stable", 32'(stable), 32'd1);
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bus_unexpected: got addr %h wstrb %h, expected no bus cycle", a, s);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_addr", a, e.addr);
                    check("bus_wstrb", 32'(s), 32'(e.wstrb));
                    if (e.wstrb == 4'hF) check("bus_wdata", d, e.wdata);
                    if (e.dur >= 0) check("bus_valid_cycles", 32'(dur), 32'(e.dur));
                    $display("bus: addr=%h wstrb=%h wdata=%h cycles=%0d", a, s, d, dur);
                end
            end
        end
    end

    // TX line monitor
    initial begin
        tx_exp_t    e;
        longint     t0, last_start;
        logic [7:0] b;
        logic       stop_bit;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !reset) begin
                t0 = cyc;
                repeat (BAUD_DIV / 2) @(negedge clk);
                check("tx_start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BAUD_DIV) @(negedge clk);
                stop_bit = tx;
                check("tx_stop_bit", 32'(stop_bit), 32'd1);
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: got byte %h, expected none", b);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", 32'(b), 32'(e.b));
                    if (e.b2b) check("tx_frame_spacing", 32'(t0 - last_start), 32'(FRAME));
                    $display("tx: byte=%h", b);
                end
                last_start = t0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_count++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_exp_t    e;
        logic [31:0] v, a;
        logic [7:0]  bb;
        int          f0, n, r;
        for (int i = 0; i < 8; i++) begin
            v = $urandom();
            model_mem[i] = v;
            rsp_mem[i] = v;
        end
        model_mem[1] = 32'h1234_5678;
        rsp_mem[1]   = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_mem_valid", 32'(mem_valid), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed: read, write, timeout followed by write
        rsp_delay = 2;
        send_cmd(1'b0, 32'h8000_0204, 32'h0);
        rsp_delay = 3;
        send_cmd(1'b1, 32'h8000_0204, 32'h0000_000A);
        send_cmd(1'b0, 32'h9000_0000, 32'h0);
        rsp_delay = 1;
        send_cmd(1'b1, 32'h8000_0210, $urandom());

        // Unknown command
        push_tx(8'h3F, 1'b0);
        send_byte(8'hAA, 1'b1);
        wait_idle();

        // Short low glitch must not produce a byte
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // Framing error on second address byte aborts the command
        f0 = ferr_count;
        send_byte(8'h57, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (FRAME) @(negedge clk);
        check("frame_err_pulses", 32'(ferr_count - f0), 32'd1);
        rsp_delay = 0;
        send_cmd(1'b1, 32'h8000_0208, $urandom());

        // Reset while the bus cycle is outstanding
        e.addr = 32'h9000_0000;
        e.wdata = 32'h0;
        e.wstrb = 4'h0;
        e.dur = -1;
        bus_q.push_back(e);
        send_byte(8'h52, 1'b1);
        send_byte(8'h90, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        n = 0;
        while (mem_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("bus_started_before_reset", 32'(mem_valid), 32'd1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_mem_valid", 32'(mem_valid), 32'd0);
        check("async_reset_tx", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_idle();
        rsp_delay = 2;
        send_cmd(1'b1, 32'h8000_021C, $urandom());

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            rsp_delay = $urandom_range(0, 6);
            if (r == 0) begin
                bb = 8'($urandom());
                if (bb == 8'h57 || bb == 8'h52) bb = 8'hAA;
                push_tx(8'h3F, 1'b0);
                send_byte(bb, 1'b1);
                wait_idle();
            end else begin
                if (r == 1) a = 32'h4000_0000 + (32'($urandom_range(0, 255)) << 2);
                else        a = 32'h8000_0200 + (32'($urandom_range(0, 7)) << 2);
                send_cmd(r[0], a, $urandom());
            end
        end

        repeat (FRAME) @(negedge clk);
        check("frame_err_total", 32'(ferr_count), 32'd1);
        check("queues_empty", 32'(bus_q.size() + tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial-to-bus debug bridge, the initiator end of the picoRV native memory interface that the uart peripheral answers as a responder.
- Receives 8N1 command frames on rx and issues single read or write transactions on the mem_* bus.
- Returns an acknowledge byte or read data on tx.
- Lets a host PC poke peripherals, e.g. uart registers at 0x80000200..0x8000021F, without the CPU.

Parameters:
- BAUD_DIV, 10, clock cycles per serial bit; must be >= 4.
- TIMEOUT, 64, cycles to wait for mem_ready before abandoning a transaction; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- mem_valid  out  1  transaction request
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 for a write, 4'b0000 for a read
- mem_ready  in  1  responder done; mem_rdata valid in the same cycle
- mem_rdata  in  32  read data
- frame_err  out  1  one-cycle pulse when a received byte has stop bit = 0

Behaviour:
- Reset values: tx=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, frame_err=0. FSM goes to IDLE and both serial engines go idle.
- Reset asserted mid-operation aborts immediately. mem_valid drops asynchronously and no response is sent.
- RX synchronisation: rx passes through a 2-flop synchroniser; a start bit is a synchronised high-to-low edge.
- RX start check: sample at BAUD_DIV/2 cycles after the edge. If the line is high there, treat it as a glitch and return to idle with no byte.
- RX data: 8 data bits LSB first, then the stop bit, each sampled every BAUD_DIV cycles from the start sample.
- RX byte valid: a byte is valid in the cycle its stop sample is 1. Stop sample 0 pulses frame_err and discards the byte.
- TX: start bit, 8 data bits LSB first, stop bit, each held exactly BAUD_DIV cycles. Back-to-back bytes have no extra idle gap.
- Command framing: all multi-byte fields are MSB first.
  - 0x57 'W': 4 address bytes, then 4 data bytes.
  - 0x52 'R': 4 address bytes.
- FSM states:
  - IDLE --byte 0x57--> ADDR (write flag set)
  - IDLE --byte 0x52--> ADDR (write flag clear)
  - IDLE --any other byte--> RESP, sending 0x3F '?'
  - ADDR: shift 4 bytes into mem_addr, then go to DATA for a write or BUS for a read.
  - DATA: shift 4 bytes into mem_wdata, then go to BUS.
  - BUS: mem_valid=1, with mem_wstrb set per the write flag.
    - On mem_ready=1: capture mem_rdata, drop mem_valid on the next edge, go to RESP.
    - If TIMEOUT cycles pass with no ready: drop mem_valid, go to RESP with 0x54 'T'.
  - RESP: a write sends 0x4B 'K'; a read sends 4 rdata bytes; then return to IDLE.
- Latency: mem_valid rises on the clock edge after the final command byte is valid. TX of the first response byte starts on the edge after leaving BUS.
- mem_addr, mem_wdata and mem_wstrb stay stable for the whole time mem_valid is high. mem_ready while mem_valid=0 is ignored.
- Timeout counter clears on entering BUS. mem_ready in the same cycle the counter reaches TIMEOUT counts as success.
- Bytes received in BUS or RESP are dropped; the RX engine keeps running so it does not lose frame alignment.
- A framing error in ADDR or DATA aborts the command: return to IDLE, no bus cycle, no response.
- A read with mem_rdata=0 still sends four 0x00 bytes.

Decomposition:
- Shared package holds:
  - command/response byte constants CMD_WRITE=0x57, CMD_READ=0x52, RSP_ACK=0x4B, RSP_ERR=0x3F, RSP_TIMEOUT=0x54
  - FSM state encoding
  - helper for the baud-counter width: clog2(BAUD_DIV)
- One sub-module, uart_serdes: RX deserialiser plus TX serialiser.
  - Outputs: rx_byte, rx_valid, rx_ferr.
  - Inputs: tx_byte, tx_start. Output: tx_busy.
- The command FSM and bus logic stay in the top module.

Test Plan:
- Bench setup: BAUD_DIV=10; the bench responder decodes 0x80000200..0x8000021F.
- Write: send 57 80 00 02 04 00 00 00 0A; responder raises mem_ready 3 cycles after mem_valid -> one transaction with addr=0x80000204, wdata=0x0000000A, wstrb=4'hF; tx returns 0x4B; mem_valid high exactly 4 cycles.
- Read: send 52 80 00 02 04; responder returns 0x12345678 -> wstrb=0; tx returns 12 34 56 78 back-to-back, each frame exactly 100 cycles.
- Timeout: TIMEOUT=64, read of 0x90000000 with no ready -> mem_valid drops after 64 cycles, tx returns 0x54; a following valid write completes normally.
- Bad command: send 0xAA -> no mem_valid, tx returns 0x3F. A 3-cycle low glitch on rx -> no byte and no response.
- Framing error: second address byte sent with stop=0 -> frame_err pulses once, no bus cycle, no response; the next write command works.
- Reset mid-BUS: assert reset while mem_valid=1 -> mem_valid=0 and tx=1 immediately without waiting for a clock; after release a full write transaction succeeds.
